// File: rtl/snn_tick_pkg.sv
// Shared types and defaults for the per-core tick-completion controller.
package snn_tick_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        READY  = 2'd3
    } tick_state_e;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_TO_W  = 16;

endpackage

// File: rtl/pkt_popcount.sv
// Combinational population count over NUM_PORTS packet-accept pulses.
module pkt_popcount #(
    parameter int NUM_PORTS = 4,
    parameter int PC_W      = $clog2(NUM_PORTS + 1)
) (
    input  logic [NUM_PORTS-1:0] bits,
    output logic [PC_W-1:0]      count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            count = count + PC_W'(bits[i]);
        end
    end

endmodule

// File: rtl/tick_sync_ctrl.sv
// Tick-completion controller: counts emitted vs delivered packets per timestep
// and pulses tick_ready once the grid is done and the counts balance.
module tick_sync_ctrl
    import snn_tick_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TO_W      = DEF_TO_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [NUM_PORTS-1:0] pkt_sent,
    input  logic                 pkt_recv,
    input  logic                 grid_done,
    input  logic [TO_W-1:0]      timeout_limit,
    output logic                 tick_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     sent_count,
    output logic [CNT_W-1:0]     recv_count,
    output logic                 overflow_err,
    output logic                 timeout_err,
    output logic                 tick_err
);

    localparam int PC_W = $clog2(NUM_PORTS + 1);

    tick_state_e       state;
    logic [TO_W-1:0]   to_cnt;
    logic [PC_W-1:0]   sent_inc;
    logic [CNT_W:0]    sent_sum;
    logic [CNT_W:0]    recv_sum;
    logic              counting;
    logic              balanced;
    logic              to_hit;

    // MSB of the result flags that the add would have exceeded the counter range.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [PC_W-1:0]  inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W + 1)'(inc);
        if (sum[CNT_W]) begin
            sum = {1'b1, {CNT_W{1'b1}}};
        end
        return sum;
    endfunction

    pkt_popcount #(
        .NUM_PORTS (NUM_PORTS),
        .PC_W      (PC_W)
    ) u_popcount (
        .bits  (pkt_sent),
        .count (sent_inc)
    );

    always_comb begin
        counting = (state == ACTIVE) || (state == DRAIN);
        sent_sum = sat_add(sent_count, sent_inc);
        recv_sum = sat_add(recv_count, PC_W'(pkt_recv));
        balanced = (sent_sum[CNT_W-1:0] == recv_sum[CNT_W-1:0]);
        to_hit   = (timeout_limit != '0) && (to_cnt == timeout_limit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            to_cnt       <= '0;
            sent_count   <= '0;
            recv_count   <= '0;
            tick_ready   <= 1'b0;
            busy         <= 1'b0;
            overflow_err <= 1'b0;
            timeout_err  <= 1'b0;
            tick_err     <= 1'b0;
        end else begin
            tick_ready <= 1'b0;

            // Shared by ACTIVE and DRAIN: count traffic and flag stray ticks.
            if (counting) begin
                sent_count <= sent_sum[CNT_W-1:0];
                recv_count <= recv_sum[CNT_W-1:0];
                if (sent_sum[CNT_W] || recv_sum[CNT_W]) begin
                    overflow_err <= 1'b1;
                end
                if (tick) begin
                    tick_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state      <= ACTIVE;
                        busy       <= 1'b1;
                        sent_count <= '0;
                        recv_count <= '0;
                        to_cnt     <= '0;
                    end
                end
                ACTIVE: begin
                    if (grid_done) begin
                        state  <= DRAIN;
                        to_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (balanced) begin
                        state      <= READY;
                        tick_ready <= 1'b1;
                        busy       <= 1'b0;
                    end else if (to_hit) begin
                        state       <= READY;
                        tick_ready  <= 1'b1;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                READY: begin
                    state <= IDLE;
                    if (tick) begin
                        tick_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tick_sync_ctrl.sv
// Directed bench for tick_sync_ctrl (NUM_PORTS=4, CNT_W=4) with a per-cycle reference model.
module tb_tick_sync_ctrl;

    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [3:0]  pkt_sent;
    logic        pkt_recv;
    logic        grid_done;
    logic [15:0] timeout_limit;
    logic        tick_ready;
    logic        busy;
    logic [3:0]  sent_count;
    logic [3:0]  recv_count;
    logic        overflow_err;
    logic        timeout_err;
    logic        tick_err;

    int total = 0;
    int bad   = 0;

    // Reference model: whole-timestep view using unbounded integer counts.
    bit m_in_tick, m_drain, m_ready, m_ovf, m_to, m_terr;
    int m_sent, m_recv, m_drain_cyc;

    tick_sync_ctrl #(
        .NUM_PORTS (4),
        .CNT_W     (4),
        .TO_W      (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .pkt_sent      (pkt_sent),
        .pkt_recv      (pkt_recv),
        .grid_done     (grid_done),
        .timeout_limit (timeout_limit),
        .tick_ready    (tick_ready),
        .busy          (busy),
        .sent_count    (sent_count),
        .recv_count    (recv_count),
        .overflow_err  (overflow_err),
        .timeout_err   (timeout_err),
        .tick_err      (tick_err)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit t, input logic [3:0] s,
                              input bit r, input bit g);
        if (rst) begin
            m_in_tick = 0; m_drain = 0; m_ready = 0;
            m_ovf = 0; m_to = 0; m_terr = 0;
            m_sent = 0; m_recv = 0; m_drain_cyc = 0;
        end else if (m_ready) begin
            m_ready = 0;
            if (t) m_terr = 1;
        end else if (!m_in_tick) begin
            if (t) begin
                m_in_tick = 1; m_sent = 0; m_recv = 0; m_drain_cyc = 0;
            end
        end else begin
            if (t) m_terr = 1;
            m_sent += $countones(s);
            m_recv += int'(r);
            if (m_sent > CMAX || m_recv > CMAX) m_ovf = 1;
            if (!m_drain) begin
                if (g) begin
                    m_drain = 1; m_drain_cyc = 0;
                end
            end else if (clamp(m_sent) == clamp(m_recv)) begin
                m_ready = 1; m_in_tick = 0; m_drain = 0;
            end else if (timeout_limit != 0 && m_drain_cyc == int'(timeout_limit)) begin
                m_to = 1; m_ready = 1; m_in_tick = 0; m_drain = 0;
            end else begin
                m_drain_cyc++;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare on the falling edge.
    task automatic step(input bit t, input logic [3:0] s, input bit r, input bit g);
        tick = t; pkt_sent = s; pkt_recv = r; grid_done = g;
        @(posedge clk);
        model_edge(reset, t, s, r, g);
        @(negedge clk);
        chk("tick_ready",   int'(tick_ready),   int'(m_ready));
        chk("busy",         int'(busy),         int'(m_in_tick));
        chk("sent_count",   int'(sent_count),   clamp(m_sent));
        chk("recv_count",   int'(recv_count),   clamp(m_recv));
        chk("overflow_err", int'(overflow_err), int'(m_ovf));
        chk("timeout_err",  int'(timeout_err),  int'(m_to));
        chk("tick_err",     int'(tick_err),     int'(m_terr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'b0000, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 4'b0000, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; tick = 0; pkt_sent = '0; pkt_recv = 0; grid_done = 0;
        timeout_limit = '0;

        // Reset state
        do_reset();
        chk("lit_reset_busy", int'(busy), 0);
        chk("lit_reset_sent", int'(sent_count), 0);

        // Basic tick: 3 sent on port 0, 3 delivered
        step(1, 4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 4'b0001, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 4'b0000, 1, 0);
        step(0, 4'b0000, 0, 1);
        chk("lit_t1_ready_early", int'(tick_ready), 0);
        idle(1);
        chk("lit_t1_ready", int'(tick_ready), 1);
        chk("lit_t1_sent", int'(sent_count), 3);
        chk("lit_t1_recv", int'(recv_count), 3);
        idle(1);
        chk("lit_t1_pulse_len", int'(tick_ready), 0);

        // Pulses while idle are ignored
        step(0, 4'b1111, 1, 0);
        chk("lit_idle_sent_hold", int'(sent_count), 3);

        // Zero-packet tick
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 1);
        idle(1);
        chk("lit_t2_ready", int'(tick_ready), 1);
        chk("lit_t2_sent", int'(sent_count), 0);
        idle(1);

        // Multi-port emission coinciding with delivery
        step(1, 4'b0000, 0, 0);
        step(0, 4'b1011, 1, 0);
        chk("lit_t3_sent", int'(sent_count), 3);
        chk("lit_t3_recv", int'(recv_count), 1);
        step(0, 4'b0000, 0, 1);
        step(0, 4'b0000, 1, 0);
        chk("lit_t3_not_ready", int'(tick_ready), 0);
        step(0, 4'b0000, 1, 0);
        chk("lit_t3_ready", int'(tick_ready), 1);
        idle(1);

        // Sent counter saturation at 15 after 17 pulses
        step(1, 4'b0000, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 4'b1111, 0, 0);
        step(0, 4'b0001, 0, 0);
        chk("lit_t4_sent_sat", int'(sent_count), 15);
        chk("lit_t4_ovf", int'(overflow_err), 1);
        step(0, 4'b0000, 0, 1);
        for (int i = 0; i < 15; i++) step(0, 4'b0000, 1, 0);
        chk("lit_t4_ready", int'(tick_ready), 1);
        idle(1);
        do_reset();

        // Timeout: 2 sent, 1 delivered, limit 10
        timeout_limit = 16'd10;
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0001, 0, 0);
        step(0, 4'b0100, 0, 0);
        step(0, 4'b0000, 1, 0);
        step(0, 4'b0000, 0, 1);
        idle(10);
        chk("lit_t5_not_yet", int'(tick_ready), 0);
        chk("lit_t5_to_clear", int'(timeout_err), 0);
        idle(1);
        chk("lit_t5_ready", int'(tick_ready), 1);
        chk("lit_t5_to_err", int'(timeout_err), 1);
        idle(1);
        timeout_limit = '0;

        // Tick during ACTIVE, then reset mid-DRAIN
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0011, 0, 0);
        step(1, 4'b0000, 0, 0);
        chk("lit_t6_tick_err", int'(tick_err), 1);
        chk("lit_t6_sent_kept", int'(sent_count), 2);
        step(0, 4'b0000, 0, 1);
        idle(2);
        chk("lit_t6_drain_busy", int'(busy), 1);
        do_reset();
        chk("lit_t6_rst_busy", int'(busy), 0);
        chk("lit_t6_rst_terr", int'(tick_err), 0);
        chk("lit_t6_rst_to", int'(timeout_err), 0);
        chk("lit_t6_rst_sent", int'(sent_count), 0);

        // Tick arriving in READY: flagged and dropped
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 1);
        idle(1);
        step(1, 4'b0000, 0, 0);
        chk("lit_rdy_tick_err", int'(tick_err), 1);
        chk("lit_rdy_idle", int'(busy), 0);
        idle(2);
        chk("lit_rdy_stay_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
